cas_buf_arbiter: RTL and testbench

CAS_BUF_ARBITER -- requirements
Module: cas_buf_arbiter

---
 rtl/cas_buf_pkg.sv | 15 +
 rtl/cas_buf_arbiter.sv | 155 +++++++++++++++
 tb/tb_cas_buf_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cas_buf_pkg.sv
// Shared definitions for the CAS tape-buffer arbiter: FSM state encoding and
// the default DDRAM byte-address width.
package cas_buf_pkg;

  localparam int CAS_ADDR_W = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } cas_state_t;

endpackage

// File: rtl/cas_buf_arbiter.sv
// Arbitrates one DDRAM tape buffer between the CAS download port (writes) and
// the tape player (reads), with a one-entry read cache and end-of-image detection.
module cas_buf_arbiter
  import cas_buf_pkg::*;
#(
  parameter int ADDR_W = CAS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_wait,
  input  logic              tp_rd,
  input  logic [ADDR_W-1:0] tp_addr,
  output logic [7:0]        tp_data,
  output logic              tp_valid,
  output logic              tp_eof,
  output logic              tp_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] cas_size
);

  cas_state_t        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        din_reg;
  logic              seen_low_reg;
  logic [ADDR_W-1:0] cache_addr_reg;
  logic [7:0]        cache_data_reg;
  logic              cache_valid_reg;
  logic [ADDR_W-1:0] cas_size_reg;
  logic              dl_active_d_reg;
  logic [7:0]        tp_data_reg;
  logic              tp_valid_reg;
  logic              tp_eof_reg;

  logic              rd_accept;
  logic              wait_done;
  logic              wr_done;
  logic [ADDR_W-1:0] wr_end;

  assign tp_busy   = (state_reg != ST_IDLE) || dl_active;
  // A coincident dl_wr wins; the read is simply dropped.
  assign rd_accept = (state_reg == ST_IDLE) && !dl_wr && tp_rd && !dl_active;
  // Completion needs the buffer to have gone busy first, so the ready level
  // seen in the issue cycle is never mistaken for completion.
  assign wait_done = seen_low_reg && mem_ready;
  assign wr_done   = (state_reg == ST_WR_WAIT) && wait_done;
  assign wr_end    = addr_reg + ADDR_W'(1);

  assign mem_we   = (state_reg == ST_WR_ISSUE) && mem_ready;
  assign mem_rd   = (state_reg == ST_RD_ISSUE) && mem_ready;
  assign mem_addr = addr_reg;
  assign mem_din  = din_reg;
  assign dl_wait  = ((state_reg == ST_IDLE) && dl_wr) ||
                    (state_reg == ST_WR_ISSUE) || (state_reg == ST_WR_WAIT);

  assign tp_data  = tp_data_reg;
  assign tp_valid = tp_valid_reg;
  assign tp_eof   = tp_eof_reg;
  assign cas_size = cas_size_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      din_reg         <= 8'h00;
      seen_low_reg    <= 1'b0;
      cache_addr_reg  <= '0;
      cache_data_reg  <= 8'h00;
      cache_valid_reg <= 1'b0;
      cas_size_reg    <= '0;
      dl_active_d_reg <= 1'b0;
      tp_data_reg     <= 8'h00;
      tp_valid_reg    <= 1'b0;
      tp_eof_reg      <= 1'b0;
    end else begin
      tp_valid_reg    <= 1'b0;
      tp_eof_reg      <= 1'b0;
      dl_active_d_reg <= dl_active;

      if (dl_active && !dl_active_d_reg)
        cas_size_reg <= '0;
      else if (wr_done && (wr_end > cas_size_reg))
        cas_size_reg <= wr_end;

      case (state_reg)
        ST_IDLE: begin
          if (dl_wr) begin
            addr_reg  <= dl_addr;
            din_reg   <= dl_data;
            state_reg <= ST_WR_ISSUE;
          end else if (rd_accept) begin
            if (tp_addr >= cas_size_reg) begin
              tp_valid_reg <= 1'b1;
              tp_eof_reg   <= 1'b1;
              tp_data_reg  <= 8'h00;
            end else if (cache_valid_reg && (cache_addr_reg == tp_addr)) begin
              tp_valid_reg <= 1'b1;
              tp_data_reg  <= cache_data_reg;
            end else begin
              addr_reg  <= tp_addr;
              state_reg <= ST_RD_ISSUE;
            end
          end
        end

        ST_WR_ISSUE: begin
          if (mem_ready) begin
            seen_low_reg <= 1'b0;
            state_reg    <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          if (!mem_ready) begin
            seen_low_reg <= 1'b1;
          end else if (seen_low_reg) begin
            cache_valid_reg <= 1'b0;
            state_reg       <= ST_IDLE;
          end
        end

        ST_RD_ISSUE: begin
          if (mem_ready) begin
            seen_low_reg <= 1'b0;
            state_reg    <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (!mem_ready) begin
            seen_low_reg <= 1'b1;
          end else if (seen_low_reg) begin
            tp_data_reg     <= mem_dout;
            tp_valid_reg    <= 1'b1;
            cache_addr_reg  <= addr_reg;
            cache_data_reg  <= mem_dout;
            cache_valid_reg <= 1'b1;
            state_reg       <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_buf_arbiter.sv
// Scoreboard bench for cas_buf_arbiter: a behavioural DDRAM model, a reference
// model of buffer contents/size/cache, and a monitor checking every tp_valid.
module tb_cas_buf_arbiter;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          reset;
  logic          dl_active;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wait;
  logic          tp_rd;
  logic [AW-1:0] tp_addr;
  logic [7:0]    tp_data;
  logic          tp_valid;
  logic          tp_eof;
  logic          tp_busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [7:0]    mem_dout;
  logic          mem_ready;
  logic [AW-1:0] cas_size;

  cas_buf_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wait(dl_wait),
    .tp_rd(tp_rd), .tp_addr(tp_addr), .tp_data(tp_data), .tp_valid(tp_valid),
    .tp_eof(tp_eof), .tp_busy(tp_busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .cas_size(cas_size)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- DDRAM model ----------------
  logic [7:0]    buf_mem [0:63];
  int            mem_lat = 3;      // 0 selects a random latency per command
  int            last_lat = 0;
  int            we_cnt = 0;
  int            rd_cnt = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [7:0]    last_we_data = 8'h00;

  initial begin
    logic is_rd;
    int   a;
    int   lat;
    mem_ready = 1'b1;
    mem_dout  = 8'h00;
    for (int i = 0; i < 64; i++) buf_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_ready && (mem_we || mem_rd)) begin
        is_rd    = mem_rd;
        a        = int'(mem_addr[5:0]);
        lat      = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
        last_lat = lat;
        if (mem_we) begin
          we_cnt++;
          last_we_addr = mem_addr;
          last_we_data = mem_din;
          buf_mem[a]   = mem_din;
        end else begin
          rd_cnt++;
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_dout  = 8'($urandom);
        repeat (lat) @(posedge clk);
        #1;
        if (is_rd) mem_dout = buf_mem[a];
        mem_ready = 1'b1;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic       eof;
    logic       fast;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [0:63];
  int         model_size = 0;
  int         model_cache = -1;
  logic [7:0] last_tp_data = 8'h00;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_tp_data = 8'h00;
      end else if (tp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tp_valid", tp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("tp_data", tp_data, e.data);
          check("tp_eof", tp_eof, e.eof);
          if (e.fast) check("tp_latency", cyc, e.cyc + 1);
          $display("read done: data=%02h eof=%0b cycle=%0d", tp_data, tp_eof, cyc);
        end
        last_tp_data = tp_data;
      end else begin
        check("tp_data_hold", tp_data, last_tp_data);
      end
    end
  end

  task automatic do_read(input int a);
    exp_t e;
    int   rd0;
    int   exp_rd;
    int   n;
    @(posedge clk);
    #1;
    rd0   = rd_cnt;
    e.cyc = cyc;
    if (a >= model_size) begin
      e.data = 8'h00; e.eof = 1'b1; e.fast = 1'b1; exp_rd = 0;
    end else if (a == model_cache) begin
      e.data = model_mem[a]; e.eof = 1'b0; e.fast = 1'b1; exp_rd = 0;
    end else begin
      e.data = model_mem[a]; e.eof = 1'b0; e.fast = 1'b0; exp_rd = 1;
      model_cache = a;
    end
    exp_q.push_back(e);
    tp_rd   = 1'b1;
    tp_addr = AW'(a);
    @(negedge clk);
    check("tp_busy_at_rd", tp_busy, 1'b0);
    @(posedge clk);
    #1;
    tp_rd   = 1'b0;
    tp_addr = AW'($urandom);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL read_timeout: addr %0d got no tp_valid within 60 cycles", a);
      exp_q.delete();
    end
    @(negedge clk);
    check("mem_rd_count", rd_cnt - rd0, exp_rd);
    $display("read addr=%0d expect data=%02h eof=%0b mem_rd=%0d", a, e.data, e.eof, exp_rd);
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input bit coincide, input int ra);
    int we0;
    int rd0;
    int n;
    int span;
    bit done;
    @(posedge clk);
    #1;
    we0     = we_cnt;
    rd0     = rd_cnt;
    dl_wr   = 1'b1;
    dl_addr = AW'(a);
    dl_data = d;
    if (coincide) begin
      tp_rd   = 1'b1;
      tp_addr = AW'(ra);
    end
    @(negedge clk);
    check("dl_wait_strobe", dl_wait, 1'b1);
    @(posedge clk);
    #1;
    dl_wr   = 1'b0;
    tp_rd   = 1'b0;
    dl_addr = AW'($urandom);
    dl_data = 8'($urandom);
    tp_addr = AW'($urandom);
    if (coincide) begin
      @(negedge clk);
      check("tp_busy_after_coincide", tp_busy, 1'b1);
    end
    span = coincide ? 2 : 1;
    done = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      if (!dl_wait) done = 1'b1;
      else span++;
      n++;
    end
    model_mem[a] = d;
    if (a + 1 > model_size) model_size = a + 1;
    model_cache = -1;
    check("dl_wait_span", span, last_lat + 3);
    check("mem_we_count", we_cnt - we0, 1);
    check("mem_we_addr", last_we_addr, a);
    check("mem_we_data", last_we_data, d);
    check("no_mem_rd_on_write", rd_cnt - rd0, 0);
    check("cas_size", cas_size, model_size);
    $display("write addr=%0d data=%02h span=%0d cas_size=%0d", a, d, span, cas_size);
  endtask

  task automatic start_load();
    @(posedge clk);
    #1;
    dl_active  = 1'b1;
    model_size = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cas_size_cleared", cas_size, 0);
    check("tp_busy_dl_active", tp_busy, 1'b1);
  endtask

  task automatic end_load();
    @(posedge clk);
    #1;
    dl_active = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            a;
    int            prev;
    int            n;
    logic [7:0]    wr_vals [0:3];
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    wr_vals[0] = 8'h11; wr_vals[1] = 8'h22; wr_vals[2] = 8'hA5; wr_vals[3] = 8'h33;
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = 8'h00;
    tp_rd = 1'b0; tp_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dl_wait", dl_wait, 1'b0);
    check("rst_tp_valid", tp_valid, 1'b0);
    check("rst_tp_eof", tp_eof, 1'b0);
    check("rst_tp_busy", tp_busy, 1'b0);
    check("rst_tp_data", tp_data, 8'h00);
    check("rst_mem_cmd", {mem_we, mem_rd}, 2'b00);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_cas_size", cas_size, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load four bytes with a fixed 3-cycle busy period each
    mem_lat = 3;
    start_load();
    for (int i = 0; i < 4; i++) do_write(i, wr_vals[i], 1'b0, 0);
    end_load();

    // Miss then hit on address 2, then read past the image
    do_read(2);
    do_read(2);
    do_read(4);

    // Write and read in the same idle cycle: read is dropped
    do_write(1, 8'h5C, 1'b1, 3);
    do_read(2);
    do_read(1);

    // Randomised load and readback
    mem_lat = 0;
    start_load();
    for (int i = 0; i < 8; i++) do_write(int'($urandom_range(0, 15)), 8'($urandom), 1'b0, 0);
    end_load();
    prev = 0;
    for (int i = 0; i < 25; i++) begin
      a = ($urandom_range(0, 2) == 0) ? prev : int'($urandom_range(0, 19));
      do_read(a);
      prev = a;
    end

    // Reset while a read waits on the buffer
    mem_lat = 6;
    do_write(5, 8'h6B, 1'b0, 0);
    rd_cnt = rd_cnt;
    @(posedge clk);
    #1;
    n = rd_cnt;
    tp_rd   = 1'b1;
    tp_addr = AW'(5);
    @(posedge clk);
    #1;
    tp_rd = 1'b0;
    a = 0;
    while (rd_cnt == n && a < 20) begin
      @(posedge clk);
      a++;
    end
    check("rd_before_reset", rd_cnt - n, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    model_size  = 0;
    model_cache = -1;
    @(negedge clk);
    check("rst2_dl_wait", dl_wait, 1'b0);
    check("rst2_tp_busy", tp_busy, 1'b0);
    check("rst2_mem_cmd", {mem_we, mem_rd}, 2'b00);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_cas_size", cas_size, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("cas_size_after_reset", cas_size, 0);
    mem_lat = 3;
    do_read(0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
